// File: rtl/rv_ctrl_pkg.sv
// Opcodes, FSM state and datapath selector encodings shared by the RV32I
// multi-cycle controller and its ack timer.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R     = 7'd51;
  localparam logic [6:0] OP_I     = 7'd19;
  localparam logic [6:0] OP_ST    = 7'd35;
  localparam logic [6:0] OP_LUI   = 7'd55;
  localparam logic [6:0] OP_AUIPC = 7'd23;
  localparam logic [6:0] OP_JAL   = 7'd111;
  localparam logic [6:0] OP_JALR  = 7'd103;
  localparam logic [6:0] OP_LD    = 7'd3;
  localparam logic [6:0] OP_BR    = 7'd99;
  localparam logic [6:0] OP_SYS   = 7'd115;
  localparam logic [6:0] OP_NOP   = 7'd0;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_BRANCH = 2'd1, PC_JALR = 2'd2} pc_sel_e;
  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_LOAD = 2'd1, WB_PC4 = 2'd2} wb_sel_e;
  typedef enum logic [1:0] {ALU_A_RS1 = 2'd0, ALU_A_PC = 2'd1, ALU_A_ZERO = 2'd2} alu_a_sel_e;
  typedef enum logic {ALU_B_RS2 = 1'b0, ALU_B_IMM = 1'b1} alu_b_sel_e;
  typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_FUNC = 2'd1, ALU_CMP = 2'd2} alu_op_sel_e;
  typedef enum logic [1:0] {
    TRAP_NONE    = 2'd0,
    TRAP_SYSTEM  = 2'd1,
    TRAP_ILLEGAL = 2'd2,
    TRAP_TIMEOUT = 2'd3
  } trap_cause_e;

  // Opcodes the controller sequences through to retirement; SYSTEM halts instead.
  function automatic logic is_exec_opcode(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_ST, OP_LUI, OP_AUIPC, OP_JAL,
      OP_JALR, OP_LD, OP_BR, OP_NOP: is_exec_opcode = 1'b1;
      default:                       is_exec_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_ack_timer.sv
// Memory-ack wait counter: counts cycles a request waits and flags the cycle
// in which the count would reach ACK_TIMEOUT without an ack.
module rv_ack_timer #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wait_i,
  input  logic ack_i,
  output logic timeout_o
);

  localparam logic        ENABLED = (ACK_TIMEOUT != 32'd0);
  localparam int unsigned CW      = (ACK_TIMEOUT == 32'd0) ? 1 : $clog2(ACK_TIMEOUT + 32'd1);
  localparam logic [CW-1:0] LIMIT = (ACK_TIMEOUT == 32'd0) ? CW'(0) : CW'(ACK_TIMEOUT - 32'd1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The count is zero whenever no request is waiting, so it starts clean on entry.
  always_comb begin
    if (ENABLED && wait_i && !ack_i) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // An ack in the threshold cycle wins over the timeout.
  assign timeout_o = ENABLED && wait_i && !ack_i && (cnt_q == LIMIT);

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, data access and
// writeback sequencing with memory handshakes, retire counting and halt traps.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [1:0]       alu_a_sel,
  output logic             alu_b_sel,
  output logic [1:0]       alu_op_sel,
  output logic [1:0]       wb_sel,
  output logic             rf_we,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_check
    $error("RESET_PC must be word aligned");
  end

  state_e           state_q, state_d;
  logic [6:0]       op_q, op_d;
  trap_cause_e      trap_q, trap_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire_s, wait_s, ack_s, timeout_s;
  logic             is_ld_s, is_st_s, is_br_s, is_jmp_s, is_nop_s;
  alu_a_sel_e       alu_a_s;
  alu_b_sel_e       alu_b_s;
  alu_op_sel_e      alu_op_s;
  pc_sel_e          pc_sel_s;
  wb_sel_e          wb_sel_s;

  assign is_ld_s  = (op_q == OP_LD);
  assign is_st_s  = (op_q == OP_ST);
  assign is_br_s  = (op_q == OP_BR);
  assign is_jmp_s = (op_q == OP_JAL) || (op_q == OP_JALR);
  assign is_nop_s = (op_q == OP_NOP);

  // Stray acks are masked off here so only the live handshake is seen.
  assign wait_s = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign ack_s  = ((state_q == ST_FETCH) && imem_ack) || ((state_q == ST_MEM) && dmem_ack);

  rv_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_ack_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .wait_i    (wait_s),
    .ack_i     (ack_s),
    .timeout_o (timeout_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      op_q      <= OP_NOP;
      trap_q    <= TRAP_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      trap_q    <= trap_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    trap_d   = trap_q;
    retire_s = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          state_d = ST_DECODE;
        end else if (timeout_s) begin
          state_d = ST_HALT;
          trap_d  = TRAP_TIMEOUT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        op_d = opcode;
        if (opcode == OP_SYS) begin
          state_d = ST_HALT;
          trap_d  = TRAP_SYSTEM;
        end else if (!is_exec_opcode(opcode)) begin
          state_d = ST_HALT;
          trap_d  = TRAP_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_ld_s || is_st_s) begin
          state_d = ST_MEM;
        end else if (is_br_s || is_nop_s) begin
          state_d  = ST_FETCH;
          retire_s = 1'b1;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (dmem_ack) begin
          state_d  = is_st_s ? ST_FETCH : ST_WB;
          retire_s = is_st_s;
        end else if (timeout_s) begin
          state_d = ST_HALT;
          trap_d  = TRAP_TIMEOUT;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        state_d  = ST_FETCH;
        retire_s = 1'b1;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
    if (retire_s) begin
      instret_d = instret_q + CNT_W'(1);
    end else begin
      instret_d = instret_q;
    end
  end

  // Selector values depend only on the latched opcode, so they stay put from EXEC through WB.
  always_comb begin
    alu_a_s  = ALU_A_RS1;
    alu_b_s  = ALU_B_RS2;
    alu_op_s = ALU_ADD;
    pc_sel_s = PC_PLUS4;
    wb_sel_s = WB_ALU;
    case (op_q)
      OP_R:     alu_op_s = ALU_FUNC;
      OP_I:     begin alu_b_s = ALU_B_IMM; alu_op_s = ALU_FUNC; end
      OP_LUI:   begin alu_a_s = ALU_A_ZERO; alu_b_s = ALU_B_IMM; end
      OP_AUIPC: begin alu_a_s = ALU_A_PC; alu_b_s = ALU_B_IMM; end
      OP_LD:    begin alu_b_s = ALU_B_IMM; wb_sel_s = WB_LOAD; end
      OP_ST:    alu_b_s = ALU_B_IMM;
      OP_BR: begin
        alu_op_s = ALU_CMP;
        if (branch_taken) begin
          pc_sel_s = PC_BRANCH;
        end else begin
          pc_sel_s = PC_PLUS4;
        end
      end
      OP_JAL:   begin pc_sel_s = PC_BRANCH; wb_sel_s = WB_PC4; end
      OP_JALR:  begin pc_sel_s = PC_JALR; wb_sel_s = WB_PC4; end
      default:  alu_a_s = ALU_A_RS1;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 2'd0;
    alu_a_sel  = 2'd0;
    alu_b_sel  = 1'b0;
    alu_op_sel = 2'd0;
    wb_sel     = 2'd0;
    rf_we      = 1'b0;
    halted     = 1'b0;
    if (rst_n) begin
      if ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB)) begin
        pc_sel     = pc_sel_s;
        alu_a_sel  = alu_a_s;
        alu_b_sel  = alu_b_s;
        alu_op_sel = alu_op_s;
        wb_sel     = wb_sel_s;
      end else begin
        pc_sel = 2'd0;
      end
      case (state_q)
        ST_FETCH:  begin imem_req = 1'b1; ir_we = imem_ack; end
        ST_DECODE: ir_we = 1'b0;
        ST_EXEC:   pc_we = is_br_s || is_jmp_s || is_nop_s;
        ST_MEM:    begin dmem_req = 1'b1; dmem_we = is_st_s; pc_we = is_st_s && dmem_ack; end
        ST_WB:     begin rf_we = 1'b1; pc_we = !is_jmp_s; end
        ST_HALT:   halted = 1'b1;
        default:   halted = 1'b0;
      endcase
    end else begin
      halted = 1'b0;
    end
  end

  assign trap_cause = trap_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: a per-instruction timeline model
// predicts every cycle's outputs and one negedge process compares them.
module tb_rv_multicycle_ctrl;

  localparam int TMO = 4;

  logic        clk, rst_n, branch_taken, imem_ack, dmem_ack;
  logic [6:0]  opcode;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_b_sel, rf_we, halted;
  logic [1:0]  pc_sel, alu_a_sel, alu_op_sel, wb_sel, trap_cause;
  logic [31:0] instret;

  rv_multicycle_ctrl #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op_sel(alu_op_sel),
    .wb_sel(wb_sel), .rf_we(rf_we), .halted(halted), .trap_cause(trap_cause),
    .instret(instret)
  );

  typedef struct packed {
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, halted;
    logic [1:0]  pc_sel, alu_a, alu_op, wb_sel, trap;
    logic        alu_b, chk_alu;
    logic [31:0] instret;
  } exp_t;

  exp_t  exp_r;
  logic  chk_en;
  int    n_checks, n_errors, n;
  int    model_instret;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("enables", 32'({imem_req, dmem_req, ir_we, pc_we, rf_we, halted}),
            32'({exp_r.imem_req, exp_r.dmem_req, exp_r.ir_we, exp_r.pc_we, exp_r.rf_we, exp_r.halted}));
      if (exp_r.dmem_req) check("dmem_we", 32'(dmem_we), 32'(exp_r.dmem_we));
      if (exp_r.pc_we)    check("pc_sel", 32'(pc_sel), 32'(exp_r.pc_sel));
      if (exp_r.rf_we)    check("wb_sel", 32'(wb_sel), 32'(exp_r.wb_sel));
      if (exp_r.chk_alu)
        check("alu_sel", 32'({alu_a_sel, alu_b_sel, alu_op_sel}), 32'({exp_r.alu_a, exp_r.alu_b, exp_r.alu_op}));
      check("trap_cause", 32'(trap_cause), 32'(exp_r.trap));
      check("instret", instret, exp_r.instret);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t blank();
    exp_t e;
    e = '0;
    e.instret = model_instret;
    return e;
  endfunction

  // {alu_a, alu_b, alu_op} the instruction class calls for.
  function automatic logic [4:0] alu_expect(input logic [6:0] op);
    case (op)
      7'd51:        return {2'd0, 1'b0, 2'd1};
      7'd19:        return {2'd0, 1'b1, 2'd1};
      7'd55:        return {2'd2, 1'b1, 2'd0};
      7'd23:        return {2'd1, 1'b1, 2'd0};
      7'd3, 7'd35:  return {2'd0, 1'b1, 2'd0};
      7'd99:        return {2'd0, 1'b0, 2'd2};
      default:      return 5'd0;
    endcase
  endfunction

  task automatic halt_phase(input logic [1:0] trap, input logic stray);
    exp_t e;
    for (int c = 0; c < 3; c++) begin
      imem_ack = stray; dmem_ack = stray;
      e = blank(); e.halted = 1'b1; e.trap = trap; exp_r = e;
      tick();
    end
  endtask

  task automatic do_reset();
    chk_en = 1'b0; rst_n = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1; opcode = 7'd51;
    tick();
    model_instret = 0; exp_r = '0; chk_en = 1'b1;
    tick();
    tick();
    rst_n = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
  endtask

  // iw/dw: wait cycles before ack; -1 never acks (timeout), dw=-2 stops after one MEM cycle.
  task automatic run_instr(input logic [6:0] op, input logic bt, input int iw, input int dw,
                           input logic stray, output int ncyc);
    exp_t e;
    logic [4:0] alu;
    bit is_ld, is_st, is_br, is_jmp, is_nop, legal, use_alu;
    int nmem;
    is_ld  = (op == 7'd3);
    is_st  = (op == 7'd35);
    is_br  = (op == 7'd99);
    is_jmp = (op == 7'd111) || (op == 7'd103);
    is_nop = (op == 7'd0);
    legal  = op inside {7'd51, 7'd19, 7'd55, 7'd23, 7'd3, 7'd35, 7'd99, 7'd111, 7'd103, 7'd0};
    use_alu = !is_jmp && !is_nop;
    alu  = alu_expect(op);
    ncyc = 0;
    chk_en = 1'b1;
    for (int c = 0; c < ((iw < 0) ? TMO : iw + 1); c++) begin
      opcode = 7'h7f; branch_taken = ~bt;
      imem_ack = (c == iw); dmem_ack = stray;
      e = blank(); e.imem_req = 1'b1; e.ir_we = (c == iw); exp_r = e;
      tick(); ncyc++;
    end
    if (iw < 0) begin halt_phase(2'd3, stray); return; end
    opcode = op; branch_taken = bt; imem_ack = stray; dmem_ack = stray;
    exp_r = blank();
    tick(); ncyc++;
    if (op == 7'd115) begin halt_phase(2'd1, stray); return; end
    if (!legal)       begin halt_phase(2'd2, stray); return; end
    e = blank();
    e.chk_alu = use_alu; {e.alu_a, e.alu_b, e.alu_op} = alu;
    e.pc_we = is_br || is_jmp || is_nop;
    e.pc_sel = is_br ? {1'b0, bt} : (op == 7'd111) ? 2'd1 : (op == 7'd103) ? 2'd2 : 2'd0;
    exp_r = e;
    tick(); ncyc++;
    if (is_br || is_nop) begin model_instret++; return; end
    if (is_ld || is_st) begin
      nmem = (dw == -2) ? 1 : (dw < 0) ? TMO : dw + 1;
      for (int c = 0; c < nmem; c++) begin
        imem_ack = stray; dmem_ack = (c == dw);
        e = blank(); e.chk_alu = 1'b1; {e.alu_a, e.alu_b, e.alu_op} = alu;
        e.dmem_req = 1'b1; e.dmem_we = is_st; e.pc_we = is_st && (c == dw); e.pc_sel = 2'd0;
        exp_r = e;
        tick(); ncyc++;
      end
      if (dw == -1) begin halt_phase(2'd3, stray); return; end
      if (dw == -2) return;
      if (is_st) begin model_instret++; return; end
    end
    imem_ack = stray; dmem_ack = stray;
    e = blank(); e.chk_alu = use_alu; {e.alu_a, e.alu_b, e.alu_op} = alu;
    e.rf_we = 1'b1; e.wb_sel = is_ld ? 2'd1 : is_jmp ? 2'd2 : 2'd0;
    e.pc_we = !is_jmp; e.pc_sel = 2'd0;
    exp_r = e;
    tick(); ncyc++;
    model_instret++;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; opcode = 7'd0; branch_taken = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0; chk_en = 1'b0; exp_r = '0;
    n_checks = 0; n_errors = 0; model_instret = 0;
    do_reset();
    run_instr(7'd51, 1'b0, 0, 0, 1'b0, n);
    check("rtype_cycles", 32'(n), 32'd4); check("rtype_instret", instret, 32'd1);
    run_instr(7'd3, 1'b0, 0, 3, 1'b1, n);  check("load_cycles", 32'(n), 32'd8);
    run_instr(7'd99, 1'b1, 0, 0, 1'b1, n); check("br_taken_cycles", 32'(n), 32'd3);
    run_instr(7'd99, 1'b0, 2, 0, 1'b0, n);
    run_instr(7'd103, 1'b0, 0, 0, 1'b1, n); check("jalr_cycles", 32'(n), 32'd4);
    run_instr(7'd111, 1'b0, 1, 0, 1'b0, n);
    run_instr(7'd55, 1'b0, 0, 0, 1'b0, n);
    run_instr(7'd23, 1'b0, 0, 0, 1'b1, n);
    run_instr(7'd19, 1'b1, 3, 0, 1'b0, n);
    run_instr(7'd35, 1'b0, 1, 2, 1'b1, n);
    run_instr(7'd35, 1'b0, 0, 0, 1'b0, n); check("store_cycles", 32'(n), 32'd4);
    run_instr(7'd0, 1'b0, 0, 0, 1'b1, n);  check("bubble_cycles", 32'(n), 32'd3);
    run_instr(7'd3, 1'b0, 3, 0, 1'b0, n);
    check("instret_13", instret, 32'd13);
    run_instr(7'd115, 1'b0, 0, 0, 1'b1, n);
    check("sys_trap", 32'(trap_cause), 32'd1); check("sys_instret", instret, 32'd13);
    do_reset();
    run_instr(7'd7, 1'b0, 0, 0, 1'b1, n);
    check("illegal_trap", 32'(trap_cause), 32'd2); check("illegal_halted", 32'(halted), 32'd1);
    do_reset();
    run_instr(7'd51, 1'b0, -1, 0, 1'b1, n);
    check("fetch_tmo_trap", 32'(trap_cause), 32'd3); check("fetch_tmo_req", 32'(imem_req), 32'd0);
    do_reset();
    run_instr(7'd51, 1'b0, 0, 0, 1'b0, n);
    run_instr(7'd35, 1'b0, 0, -1, 1'b1, n);
    check("mem_tmo_trap", 32'(trap_cause), 32'd3); check("mem_tmo_instret", instret, 32'd1);
    do_reset();
    run_instr(7'd19, 1'b0, 1, 0, 1'b0, n);
    run_instr(7'd3, 1'b0, 0, 0, 1'b0, n);
    run_instr(7'd35, 1'b0, 0, -2, 1'b1, n);
    do_reset();
    check("rst_instret", instret, 32'd0);
    run_instr(7'd51, 1'b0, 0, 0, 1'b0, n);
    check("post_rst_cycles", 32'(n), 32'd4); check("post_rst_instret", instret, 32'd1);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core.
- Sequences instruction fetch, instruction-register load, decode, execute, data-memory access and register writeback around the existing field decoder and datapath.
- Drives all datapath enables and mux selects, runs req/ack handshakes to instruction and data memory, and halts on SYSTEM, illegal opcode or memory timeout.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset; exposed to datapath for PC init.
- ACK_TIMEOUT, 255, maximum wait cycles for any memory ack before trap; 0 disables the timeout.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- opcode  in  7  opcode field from decoder (IR[6:0]).
- branch_taken  in  1  branch comparator result for current IR funct3.
- imem_req  out  1  instruction fetch request, held until ack.
- imem_ack  in  1  fetch data valid this cycle.
- dmem_req  out  1  data access request, held until ack.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req.
- dmem_ack  in  1  data access complete this cycle.
- ir_we  out  1  load instruction register.
- pc_we  out  1  update PC.
- pc_sel  out  2  0 = PC+4, 1 = PC+imm (branch/JAL), 2 = (rs1+imm) & ~1 (JALR).
- alu_a_sel  out  2  0 = rs1, 1 = PC, 2 = zero.
- alu_b_sel  out  1  0 = rs2, 1 = imm.
- alu_op_sel  out  2  0 = add, 1 = funct3/funct7 op, 2 = compare.
- wb_sel  out  2  0 = ALU, 1 = load data, 2 = PC+4.
- rf_we  out  1  register file write enable.
- halted  out  1  core stopped.
- trap_cause  out  2  0 = none, 1 = SYSTEM, 2 = illegal opcode, 3 = timeout.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=FETCH; all outputs 0; instret=0; trap_cause=0; wait counter=0.
  - Reset has priority over every state, including mid-handshake; no partial ack is remembered.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - imem_req=1.
  - On imem_ack: ir_we=1 that cycle, go to DECODE.
  - Otherwise stay and increment the wait counter.
- DECODE: one cycle; all enables 0; classify opcode; go to EXEC, or to HALT on SYSTEM (115) or an illegal opcode.
- EXEC, by opcode:
  - R (51): alu_a=0, alu_b=0, op=1 -> WB.
  - I-ALU (19): a=0, b=1, op=1 -> WB.
  - LUI (55): a=2, b=1, op=0 -> WB.
  - AUIPC (23): a=1, b=1, op=0 -> WB.
  - Load (3) / store (35): a=0, b=1, op=0 -> MEM.
  - Branch (99): op=2; pc_we=1; pc_sel=branch_taken?1:0; retire -> FETCH.
  - JAL (111): pc_we=1, pc_sel=1 -> WB.
  - JALR (103): pc_we=1, pc_sel=2 -> WB.
  - Opcode 0: bubble; pc_we=1, pc_sel=0; retire -> FETCH.
- MEM:
  - dmem_req=1; dmem_we=1 for store, 0 for load.
  - On dmem_ack: load -> WB; store -> pc_we=1, pc_sel=0, retire -> FETCH.
- WB:
  - rf_we=1 for one cycle.
  - wb_sel: 1 for load, 2 for JAL/JALR, 0 otherwise.
  - Non-jump: pc_we=1, pc_sel=0.
  - Retire -> FETCH.
- Mux selects are held stable across MEM and WB for the same instruction.
- Retire: instret increments by 1 in the cycle the FSM returns to FETCH. It wraps modulo 2^CNT_W. SYSTEM, illegal and timeout do not retire.
- Latency with 0-wait ack (ack in same cycle as req), counted in cycles:
  - ALU/LUI/AUIPC/JAL/JALR = 4.
  - Branch = 3; bubble = 3.
  - Store = 4; load = 5.
- Wait counter:
  - Cleared on entry to FETCH or MEM and on any ack.
  - Increments each FETCH/MEM cycle without ack.
  - If ACK_TIMEOUT != 0 and the counter reaches ACK_TIMEOUT with no ack: go to HALT, trap_cause=3, drop req the next cycle.
  - An ack arriving in the same cycle as the timeout threshold wins; no trap.
- HALT:
  - halted=1; all req/enables 0; trap_cause holds its value.
  - Only reset exits.
  - SYSTEM halt sets trap_cause=1; illegal opcode sets trap_cause=2.
- Requests are level signals. A req, once raised, stays high until ack or timeout; no deassert-without-ack otherwise.
- A stray ack (imem_ack or dmem_ack while the corresponding req=0) is ignored.

Decomposition:
- Package rv_ctrl_pkg holds:
  - opcode localparams (OP_R=51, OP_I=19, OP_ST=35, OP_LUI=55, OP_AUIPC=23, OP_JAL=111, OP_JALR=103, OP_LD=3, OP_BR=99, OP_SYS=115, OP_NOP=0).
  - state enum.
  - pc_sel, wb_sel and alu selector enums.
  - trap_cause enum.
- One sub-module: rv_ack_timer (wait counter + timeout compare), instantiated once.

Test Plan:
- R-type (opcode 51), imem/dmem ack immediate -> IR write cycle 1, rf_we=1 with wb_sel=0 in cycle 4, pc_sel=0, instret 0->1.
- Load (opcode 3), dmem_ack delayed 3 cycles -> dmem_req held 4 cycles with dmem_we=0; WB has rf_we=1, wb_sel=1; total 8 cycles.
- Branch (opcode 99):
  - branch_taken=1 -> pc_we=1, pc_sel=1 in cycle 3, no rf_we.
  - branch_taken=0 -> pc_sel=0.
- JALR (opcode 103) -> EXEC pc_sel=2; WB wb_sel=2, rf_we=1; instret+1.
- Opcode 115, then an illegal opcode 7 after reset -> halted=1 with trap_cause=1, then trap_cause=2; no further imem_req; instret unchanged.
- Timeout: ACK_TIMEOUT=4, never ack imem -> HALT after 4 wait cycles, trap_cause=3. Then rst_n=0 mid-MEM on a store -> next cycle state FETCH, all outputs 0, instret=0.
